// File: rtl/alu_pkg.sv
// Shared op codes and FSM encoding for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // True for the single-cycle ops handled by alu_logic_core.
  function automatic logic is_core_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Combinational AND/OR/ADD/SUB datapath plus signed less-than compare.
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             lt
);

  // Single-cycle result; carries out of the top bit are dropped.
  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a + ~b + WIDTH'(1);
      default: res = '0;
    endcase
  end

  // Signed compare feeds branch resolution independent of op.
  always_comb begin
    lt = $signed(a) < $signed(b);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative 1-bit/cycle SLL.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE, so accept and retire never share
// a cycle. Result and flags are held stable while out_valid && !out_ready.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             illegal_op,
  output logic [1:0]       state_dbg
);

  alu_state_e       state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             lt_q, lt_d;
  logic             illegal_q, illegal_d;
  logic             zero_q;
  logic [WIDTH-1:0] core_res;
  logic             core_lt;

  alu_logic_core #(.WIDTH(WIDTH)) u_core (
    .op  (Operation),
    .a   (a),
    .b   (b),
    .res (core_res),
    .lt  (core_lt)
  );

  // Next-state and datapath update; inputs are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    result_d  = result_q;
    lt_d      = lt_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lt_d = core_lt;
          if (is_core_op(Operation)) begin
            result_d  = core_res;
            illegal_d = 1'b0;
            state_d   = DONE;
          end else if (Operation == OP_SLL) begin
            result_d  = a;
            count_d   = b[SHW-1:0];
            illegal_d = 1'b0;
            state_d   = (b[SHW-1:0] == '0) ? DONE : SHIFT;
          end else begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        result_d = {result_q[WIDTH-2:0], 1'b0};
        count_d  = count_q - SHW'(1);
        if (count_q == SHW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; zero tracks the value being written to result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      result_q  <= '0;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      result_q  <= result_d;
      lt_q      <= lt_d;
      illegal_q <= illegal_d;
      zero_q    <= (result_d == '0);
    end
  end

  // Output decode straight from registers.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    result     = result_q;
    zero       = zero_q;
    lt         = lt_q;
    illegal_op = illegal_q;
    state_dbg  = state_q;
  end

endmodule
